spio_hss_multiplexer_ctl_sched: RTL and testbench

Control-frame scheduler for the HSS multiplexer transmit path. It sits between the packet dispatcher and frame assembler, which raise ack/nak, out-of-credit and channel-flow-control requests, and the frame transmitter, which consumes them. It holds one pending request per class and coalesces superseded requests. It applies an out-of-credit hold-off, and generates channel-flow-control frames both when channel state changes and on a periodic refresh timer.

---
 rtl/spio_hss_multiplexer_ctl_sched.sv | 181 ++++++++++++++++++
 tb/tb_spio_hss_multiplexer_ctl_sched.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spio_hss_multiplexer_ctl_sched.sv
// Control-frame scheduler for the HSS multiplexer transmit path.
// Holds one pending ack/nak, one out-of-credit and one channel-flow-control
// request, coalescing superseded requests. Out-of-credit repeats of the
// last-sent colour are held off for OOC_HOLDOFF cycles. CFC frames are raised
// on any change of local channel state and on a periodic refresh timer.
module spio_hss_multiplexer_ctl_sched #(
  parameter int NUM_CHANS   = 8,
  parameter int CLR_BITS    = 1,
  parameter int SEQ_BITS    = 7,
  parameter int CFC_REFRESH = 1023,
  parameter int OOC_HOLDOFF = 63
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ack_req_vld_i,
  input  logic                 ack_req_type_i,
  input  logic [CLR_BITS-1:0]  ack_req_colour_i,
  input  logic [SEQ_BITS-1:0]  ack_req_seq_i,
  input  logic                 ooc_req_vld_i,
  input  logic [CLR_BITS-1:0]  ooc_req_colour_i,
  input  logic [NUM_CHANS-1:0] cfc_loc_i,
  output logic                 ack_vld_o,
  output logic                 ack_type_o,
  output logic [CLR_BITS-1:0]  ack_colour_o,
  output logic [SEQ_BITS-1:0]  ack_seq_o,
  output logic                 ooc_vld_o,
  output logic [CLR_BITS-1:0]  ooc_colour_o,
  output logic                 cfc_vld_o,
  output logic [NUM_CHANS-1:0] cfc_val_o,
  input  logic                 ack_done_i,
  input  logic                 ooc_done_i,
  input  logic                 cfc_done_i,
  output logic [7:0]           reg_coal_o
);

  // Timers are sized to hold their reload value exactly; they never wrap.
  localparam int REF_W  = (CFC_REFRESH > 0) ? $clog2(CFC_REFRESH + 1) : 1;
  localparam int HOLD_W = (OOC_HOLDOFF > 0) ? $clog2(OOC_HOLDOFF + 1) : 1;
  localparam logic [REF_W-1:0]  REF_LOAD  = REF_W'(CFC_REFRESH);
  localparam logic [REF_W-1:0]  REF_ONE   = REF_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OOC_HOLDOFF);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic                 ack_vld_q, ack_vld_d;
  logic                 ack_type_q, ack_type_d;
  logic [CLR_BITS-1:0]  ack_colour_q, ack_colour_d;
  logic [SEQ_BITS-1:0]  ack_seq_q, ack_seq_d;
  logic [7:0]           coal_q, coal_d;

  logic                 ooc_vld_q, ooc_vld_d;
  logic [CLR_BITS-1:0]  ooc_colour_q, ooc_colour_d;
  logic [CLR_BITS-1:0]  ooc_last_q, ooc_last_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  logic                 cfc_vld_q, cfc_vld_d;
  logic [NUM_CHANS-1:0] cfc_val_q, cfc_val_d;
  logic [NUM_CHANS-1:0] cfc_last_q, cfc_last_d;
  logic [REF_W-1:0]     refresh_q, refresh_d;

  logic ooc_acc;
  logic ooc_sent;
  logic cfc_sent;
  logic cfc_trig;

  // A done pulse only counts while the matching slot is occupied.
  assign ooc_sent = ooc_done_i && ooc_vld_q;
  assign cfc_sent = cfc_done_i && cfc_vld_q;
  assign ooc_acc  = ooc_req_vld_i
                    && !(ooc_vld_q && (ooc_req_colour_i == ooc_colour_q))
                    && !((hold_q != '0) && (ooc_req_colour_i == ooc_last_q));
  assign cfc_trig = (cfc_loc_i != cfc_last_q) || (refresh_q == '0);

  // Ack slot: load when empty or being issued, otherwise coalesce (NAK wins over ACK).
  always_comb begin
    ack_vld_d    = ack_vld_q;
    ack_type_d   = ack_type_q;
    ack_colour_d = ack_colour_q;
    ack_seq_d    = ack_seq_q;
    coal_d       = coal_q;
    if (ack_req_vld_i) begin
      if (!ack_vld_q || ack_done_i) begin
        ack_vld_d    = 1'b1;
        ack_type_d   = ack_req_type_i;
        ack_colour_d = ack_req_colour_i;
        ack_seq_d    = ack_req_seq_i;
      end else begin
        if (!(!ack_type_q && ack_req_type_i)) begin
          ack_type_d   = ack_req_type_i;
          ack_colour_d = ack_req_colour_i;
          ack_seq_d    = ack_req_seq_i;
        end
        if (coal_q != 8'hFF) begin
          coal_d = coal_q + 8'd1;
        end
      end
    end else if (ack_done_i) begin
      ack_vld_d = 1'b0;
    end
  end

  // OOC slot and hold-off timer; acceptance is judged on pre-edge state.
  always_comb begin
    ooc_vld_d    = ooc_vld_q;
    ooc_colour_d = ooc_colour_q;
    ooc_last_d   = ooc_last_q;
    hold_d       = (hold_q != '0) ? (hold_q - HOLD_ONE) : hold_q;
    if (ooc_sent) begin
      hold_d     = HOLD_LOAD;
      ooc_last_d = ooc_colour_q;
      ooc_vld_d  = 1'b0;
    end
    if (ooc_acc) begin
      ooc_vld_d    = 1'b1;
      ooc_colour_d = ooc_req_colour_i;
    end
  end

  // CFC slot: value tracks live state while pending; refresh timer counts down to 0.
  always_comb begin
    cfc_vld_d  = cfc_vld_q;
    cfc_val_d  = cfc_val_q;
    cfc_last_d = cfc_last_q;
    refresh_d  = (refresh_q != '0) ? (refresh_q - REF_ONE) : refresh_q;
    if (cfc_vld_q) begin
      if (cfc_sent) begin
        cfc_last_d = cfc_val_q;
        refresh_d  = REF_LOAD;
        cfc_vld_d  = 1'b0;
      end else begin
        cfc_val_d = cfc_loc_i;
      end
    end else if (cfc_trig) begin
      cfc_vld_d = 1'b1;
      cfc_val_d = cfc_loc_i;
    end
  end

  // State registers; reset drops all pending requests immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_vld_q    <= 1'b0;
      ack_type_q   <= 1'b0;
      ack_colour_q <= '0;
      ack_seq_q    <= '0;
      coal_q       <= 8'd0;
      ooc_vld_q    <= 1'b0;
      ooc_colour_q <= '0;
      ooc_last_q   <= '0;
      hold_q       <= '0;
      cfc_vld_q    <= 1'b0;
      cfc_val_q    <= '0;
      cfc_last_q   <= '0;
      refresh_q    <= '0;
    end else begin
      ack_vld_q    <= ack_vld_d;
      ack_type_q   <= ack_type_d;
      ack_colour_q <= ack_colour_d;
      ack_seq_q    <= ack_seq_d;
      coal_q       <= coal_d;
      ooc_vld_q    <= ooc_vld_d;
      ooc_colour_q <= ooc_colour_d;
      ooc_last_q   <= ooc_last_d;
      hold_q       <= hold_d;
      cfc_vld_q    <= cfc_vld_d;
      cfc_val_q    <= cfc_val_d;
      cfc_last_q   <= cfc_last_d;
      refresh_q    <= refresh_d;
    end
  end

  assign ack_vld_o    = ack_vld_q;
  assign ack_type_o   = ack_type_q;
  assign ack_colour_o = ack_colour_q;
  assign ack_seq_o    = ack_seq_q;
  assign ooc_vld_o    = ooc_vld_q;
  assign ooc_colour_o = ooc_colour_q;
  assign cfc_vld_o    = cfc_vld_q;
  assign cfc_val_o    = cfc_val_q;
  assign reg_coal_o   = coal_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_ctl_sched.sv
// Bench for the HSS control-frame scheduler: directed scenarios plus a
// randomized run checked against a per-cycle behavioural model.
module tb_spio_hss_multiplexer_ctl_sched;
  localparam int NC   = 8;
  localparam int CB   = 1;
  localparam int SB   = 7;
  localparam int REF  = 15;
  localparam int HOLD = 7;

  logic          clk;
  logic          rst;
  logic          ack_req_vld, ack_req_type;
  logic [CB-1:0] ack_req_colour;
  logic [SB-1:0] ack_req_seq;
  logic          ooc_req_vld;
  logic [CB-1:0] ooc_req_colour;
  logic [NC-1:0] cfc_loc;
  logic          ack_vld, ack_type;
  logic [CB-1:0] ack_colour;
  logic [SB-1:0] ack_seq;
  logic          ooc_vld;
  logic [CB-1:0] ooc_colour;
  logic          cfc_vld;
  logic [NC-1:0] cfc_val;
  logic          ack_done, ooc_done, cfc_done;
  logic [7:0]    reg_coal;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          m_ack_vld, m_ack_type;
  bit [CB-1:0] m_ack_col;
  bit [SB-1:0] m_ack_seq;
  int          m_coal;
  bit          m_ooc_vld;
  bit [CB-1:0] m_ooc_col, m_ooc_last;
  int          m_hold;
  bit          m_cfc_vld;
  bit [NC-1:0] m_cfc_val, m_cfc_last;
  int          m_refresh;

  spio_hss_multiplexer_ctl_sched #(
    .NUM_CHANS(NC), .CLR_BITS(CB), .SEQ_BITS(SB),
    .CFC_REFRESH(REF), .OOC_HOLDOFF(HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .ack_req_vld_i(ack_req_vld), .ack_req_type_i(ack_req_type),
    .ack_req_colour_i(ack_req_colour), .ack_req_seq_i(ack_req_seq),
    .ooc_req_vld_i(ooc_req_vld), .ooc_req_colour_i(ooc_req_colour),
    .cfc_loc_i(cfc_loc),
    .ack_vld_o(ack_vld), .ack_type_o(ack_type), .ack_colour_o(ack_colour), .ack_seq_o(ack_seq),
    .ooc_vld_o(ooc_vld), .ooc_colour_o(ooc_colour),
    .cfc_vld_o(cfc_vld), .cfc_val_o(cfc_val),
    .ack_done_i(ack_done), .ooc_done_i(ooc_done), .cfc_done_i(cfc_done),
    .reg_coal_o(reg_coal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_ack_vld = 0; m_ack_type = 0; m_ack_col = '0; m_ack_seq = '0; m_coal = 0;
    m_ooc_vld = 0; m_ooc_col = '0; m_ooc_last = '0; m_hold = 0;
    m_cfc_vld = 0; m_cfc_val = '0; m_cfc_last = '0; m_refresh = 0;
  endtask

  // Advance the model by one cycle from the rules, using the inputs now applied.
  task automatic model_step();
    bit          n_ack_vld, n_ack_type, n_ooc_vld, n_cfc_vld;
    bit [CB-1:0] n_ack_col, n_ooc_col, n_ooc_last;
    bit [SB-1:0] n_ack_seq;
    bit [NC-1:0] n_cfc_val, n_cfc_last;
    int          n_coal, n_hold, n_refresh;
    bit          accept, sent;
    n_ack_vld = m_ack_vld; n_ack_type = m_ack_type; n_ack_col = m_ack_col;
    n_ack_seq = m_ack_seq; n_coal = m_coal;
    if (ack_req_vld) begin
      if (!m_ack_vld || ack_done) begin
        n_ack_vld = 1; n_ack_type = ack_req_type; n_ack_col = ack_req_colour; n_ack_seq = ack_req_seq;
      end else begin
        if (!(m_ack_type == 0 && ack_req_type == 1)) begin
          n_ack_type = ack_req_type; n_ack_col = ack_req_colour; n_ack_seq = ack_req_seq;
        end
        n_coal = (m_coal < 255) ? m_coal + 1 : 255;
      end
    end else if (ack_done && m_ack_vld) begin
      n_ack_vld = 0;
    end

    accept = ooc_req_vld && !(m_ooc_vld && ooc_req_colour == m_ooc_col)
             && !(m_hold > 0 && ooc_req_colour == m_ooc_last);
    sent = ooc_done && m_ooc_vld;
    n_ooc_vld = m_ooc_vld; n_ooc_col = m_ooc_col; n_ooc_last = m_ooc_last;
    n_hold = (m_hold > 0) ? m_hold - 1 : 0;
    if (sent) begin
      n_hold = HOLD; n_ooc_last = m_ooc_col; n_ooc_vld = 0;
    end
    if (accept) begin
      n_ooc_vld = 1; n_ooc_col = ooc_req_colour;
    end

    n_cfc_vld = m_cfc_vld; n_cfc_val = m_cfc_val; n_cfc_last = m_cfc_last;
    n_refresh = (m_refresh > 0) ? m_refresh - 1 : 0;
    if (m_cfc_vld) begin
      if (cfc_done) begin
        n_cfc_last = m_cfc_val; n_refresh = REF; n_cfc_vld = 0;
      end else begin
        n_cfc_val = cfc_loc;
      end
    end else if (cfc_loc != m_cfc_last || m_refresh == 0) begin
      n_cfc_vld = 1; n_cfc_val = cfc_loc;
    end

    m_ack_vld = n_ack_vld; m_ack_type = n_ack_type; m_ack_col = n_ack_col;
    m_ack_seq = n_ack_seq; m_coal = n_coal;
    m_ooc_vld = n_ooc_vld; m_ooc_col = n_ooc_col; m_ooc_last = n_ooc_last; m_hold = n_hold;
    m_cfc_vld = n_cfc_vld; m_cfc_val = n_cfc_val; m_cfc_last = n_cfc_last; m_refresh = n_refresh;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    ack_req_vld = 0; ooc_req_vld = 0; ack_done = 0; ooc_done = 0; cfc_done = 0;
  endtask

  task automatic do_reset();
    clear_strobes();
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    int n;
    cfc_loc = 8'h00;
    do_reset();
    total++;
    if (ack_vld !== 0 || ooc_vld !== 0 || cfc_vld !== 0 || reg_coal !== 0 ||
        ack_type !== 0 || ack_seq !== 0 || ack_colour !== 0 || ooc_colour !== 0 || cfc_val !== 0) begin
      bad++;
      $display("FAIL reset_values got vld=%b%b%b coal=%0d seq=%0d val=%h exp all zero",
               ack_vld, ooc_vld, cfc_vld, reg_coal, ack_seq, cfc_val);
    end
    tick();
    total++;
    if (cfc_vld !== 1 || cfc_val !== 8'h00) begin
      bad++;
      $display("FAIL reset_cfc got vld=%b val=%h exp vld=1 val=00", cfc_vld, cfc_val);
    end
    cfc_done = 1;
    tick();
    cfc_done = 0;
    total++;
    if (cfc_vld !== 0) begin
      bad++;
      $display("FAIL cfc_done_clear got vld=%b exp 0", cfc_vld);
    end
    n = 0;
    while (cfc_vld !== 1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL cfc_refresh_gap got %0d cycles exp 16", n);
    end
  endtask

  task automatic test_ack_coalesce();
    ack_req_vld = 1; ack_req_type = 1; ack_req_colour = 0; ack_req_seq = 7'd5;
    tick();
    ack_req_seq = 7'd9;
    tick();
    ack_req_vld = 0;
    total++;
    if (ack_vld !== 1 || ack_type !== 1 || ack_seq !== 7'd9 || reg_coal !== 8'd1) begin
      bad++;
      $display("FAIL ack_overwrite got vld=%b type=%b seq=%0d coal=%0d exp 1 1 9 1",
               ack_vld, ack_type, ack_seq, reg_coal);
    end
    ack_req_vld = 1; ack_req_type = 0; ack_req_seq = 7'd3;
    tick();
    ack_req_vld = 0;
    total++;
    if (ack_type !== 0 || ack_seq !== 7'd3 || reg_coal !== 8'd2) begin
      bad++;
      $display("FAIL ack_nak_over_ack got type=%b seq=%0d coal=%0d exp 0 3 2", ack_type, ack_seq, reg_coal);
    end
    ack_req_vld = 1; ack_req_type = 1; ack_req_seq = 7'd12;
    tick();
    ack_req_vld = 0;
    total++;
    if (ack_vld !== 1 || ack_type !== 0 || ack_seq !== 7'd3 || reg_coal !== 8'd3) begin
      bad++;
      $display("FAIL ack_nak_kept got vld=%b type=%b seq=%0d coal=%0d exp 1 0 3 3",
               ack_vld, ack_type, ack_seq, reg_coal);
    end
  endtask

  task automatic test_done_plus_req();
    ack_done = 1; ack_req_vld = 1; ack_req_type = 1; ack_req_seq = 7'd20;
    tick();
    ack_done = 0; ack_req_vld = 0;
    total++;
    if (ack_vld !== 1 || ack_type !== 1 || ack_seq !== 7'd20 || reg_coal !== 8'd3) begin
      bad++;
      $display("FAIL ack_done_req got vld=%b type=%b seq=%0d coal=%0d exp 1 1 20 3",
               ack_vld, ack_type, ack_seq, reg_coal);
    end
    ack_done = 1;
    tick();
    ack_done = 0;
    total++;
    if (ack_vld !== 0) begin
      bad++;
      $display("FAIL ack_done_clear got vld=%b exp 0", ack_vld);
    end
    ack_done = 1;
    tick();
    ack_done = 0;
    total++;
    if (ack_vld !== 0 || ack_seq !== 7'd20 || reg_coal !== 8'd3) begin
      bad++;
      $display("FAIL ack_idle_done got vld=%b seq=%0d coal=%0d exp 0 20 3", ack_vld, ack_seq, reg_coal);
    end
  endtask

  task automatic test_ooc_holdoff();
    ooc_req_vld = 1; ooc_req_colour = 0;
    tick();
    ooc_req_vld = 0;
    total++;
    if (ooc_vld !== 1 || ooc_colour !== 0) begin
      bad++;
      $display("FAIL ooc_load got vld=%b col=%0d exp 1 0", ooc_vld, ooc_colour);
    end
    ooc_done = 1;
    tick();                       // done edge D
    ooc_done = 0;
    total++;
    if (ooc_vld !== 0) begin
      bad++;
      $display("FAIL ooc_done_clear got vld=%b exp 0", ooc_vld);
    end
    tick(); tick();               // D+1, D+2
    ooc_req_vld = 1; ooc_req_colour = 0;
    tick();                       // D+3
    ooc_req_vld = 0;
    total++;
    if (ooc_vld !== 0) begin
      bad++;
      $display("FAIL ooc_holdoff_block got vld=%b exp 0", ooc_vld);
    end
    ooc_req_vld = 1; ooc_req_colour = 1;
    tick();                       // D+4
    ooc_req_vld = 0;
    total++;
    if (ooc_vld !== 1 || ooc_colour !== 1) begin
      bad++;
      $display("FAIL ooc_other_colour got vld=%b col=%0d exp 1 1", ooc_vld, ooc_colour);
    end
    tick(); tick();               // D+5, D+6
    ooc_req_vld = 1; ooc_req_colour = 0;
    tick();                       // D+7, timer still 1
    total++;
    if (ooc_colour !== 1) begin
      bad++;
      $display("FAIL ooc_holdoff_last_cycle got col=%0d exp 1", ooc_colour);
    end
    tick();                       // D+8, timer expired
    ooc_req_vld = 0;
    total++;
    if (ooc_vld !== 1 || ooc_colour !== 0) begin
      bad++;
      $display("FAIL ooc_holdoff_expired got vld=%b col=%0d exp 1 0", ooc_vld, ooc_colour);
    end
    ooc_done = 1;
    tick();
    ooc_done = 0;
  endtask

  task automatic test_cfc_change();
    int n;
    cfc_loc = 8'h01;
    n = 0;
    tick();
    while (!(cfc_vld === 1 && cfc_val === 8'h01) && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (cfc_vld !== 1 || cfc_val !== 8'h01) begin
      bad++;
      $display("FAIL cfc_pending_01 got vld=%b val=%h exp 1 01", cfc_vld, cfc_val);
    end
    cfc_loc = 8'h03;
    tick();
    total++;
    if (cfc_vld !== 1 || cfc_val !== 8'h03) begin
      bad++;
      $display("FAIL cfc_track got vld=%b val=%h exp 1 03", cfc_vld, cfc_val);
    end
    cfc_done = 1; cfc_loc = 8'h07;
    tick();
    cfc_done = 0;
    total++;
    if (cfc_vld !== 0) begin
      bad++;
      $display("FAIL cfc_done_gap got vld=%b exp 0", cfc_vld);
    end
    tick();
    total++;
    if (cfc_vld !== 1 || cfc_val !== 8'h07) begin
      bad++;
      $display("FAIL cfc_reassert got vld=%b val=%h exp 1 07", cfc_vld, cfc_val);
    end
    cfc_done = 1;
    tick();
    cfc_done = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ack_req_vld    = ($urandom_range(0, 2) == 0);
      ack_req_type   = $urandom_range(0, 1);
      ack_req_colour = CB'($urandom_range(0, 1));
      ack_req_seq    = SB'($urandom);
      ooc_req_vld    = ($urandom_range(0, 2) == 0);
      ooc_req_colour = CB'($urandom_range(0, 1));
      ack_done       = ($urandom_range(0, 3) == 0);
      ooc_done       = ($urandom_range(0, 4) == 0);
      cfc_done       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) cfc_loc = NC'($urandom);
      tick();
      total++;
      if (ack_vld !== m_ack_vld || ack_type !== m_ack_type || ack_colour !== m_ack_col ||
          ack_seq !== m_ack_seq) begin
        bad++;
        $display("FAIL rand_ack cyc=%0d got %b %b %0d %0d exp %b %b %0d %0d", i,
                 ack_vld, ack_type, ack_colour, ack_seq, m_ack_vld, m_ack_type, m_ack_col, m_ack_seq);
      end
      total++;
      if (reg_coal !== m_coal[7:0]) begin
        bad++;
        $display("FAIL rand_coal cyc=%0d got %0d exp %0d", i, reg_coal, m_coal);
      end
      total++;
      if (ooc_vld !== m_ooc_vld || ooc_colour !== m_ooc_col) begin
        bad++;
        $display("FAIL rand_ooc cyc=%0d got %b %0d exp %b %0d", i, ooc_vld, ooc_colour, m_ooc_vld, m_ooc_col);
      end
      total++;
      if (cfc_vld !== m_cfc_vld || cfc_val !== m_cfc_val) begin
        bad++;
        $display("FAIL rand_cfc cyc=%0d got %b %h exp %b %h", i, cfc_vld, cfc_val, m_cfc_vld, m_cfc_val);
      end
    end
    clear_strobes();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ack_req_vld = 1; ack_req_type = 1; ack_req_seq = 7'd1;
    tick();
    ack_req_seq = 7'd2;
    tick();
    ack_req_vld = 0;
    ooc_req_vld = 1; ooc_req_colour = 1;
    tick();
    ooc_req_vld = 0;
    total++;
    if (ack_vld !== 1 || ooc_vld !== 1 || cfc_vld !== 1 || reg_coal !== 8'd1) begin
      bad++;
      $display("FAIL mid_pre got vld=%b%b%b coal=%0d exp 111 1", ack_vld, ooc_vld, cfc_vld, reg_coal);
    end
    #2 rst = 1;
    #1;
    total++;
    if (ack_vld !== 0 || ooc_vld !== 0 || cfc_vld !== 0 || reg_coal !== 0 || ack_type !== 0 ||
        ack_seq !== 0 || ooc_colour !== 0 || cfc_val !== 0 || ack_colour !== 0) begin
      bad++;
      $display("FAIL mid_reset got vld=%b%b%b coal=%0d seq=%0d col=%0d val=%h exp all zero",
               ack_vld, ooc_vld, cfc_vld, reg_coal, ack_seq, ooc_colour, cfc_val);
    end
    do_reset();
    tick();
    total++;
    if (cfc_vld !== 1 || ack_vld !== 0 || ooc_vld !== 0) begin
      bad++;
      $display("FAIL post_reset_cfc got vld=%b%b%b exp 001", ack_vld, ooc_vld, cfc_vld);
    end
  endtask

  initial begin
    rst = 1;
    ack_req_type = 0; ack_req_colour = '0; ack_req_seq = '0; ooc_req_colour = '0;
    cfc_loc = '0;
    clear_strobes();
    model_reset();
    test_reset();
    test_ack_coalesce();
    test_done_plus_req();
    test_ooc_holdoff();
    test_cfc_change();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
